// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: instruction memory port plus IF/ID handshake.
// master = fetch unit side, slave = memory / decode side.
interface fetch_queue_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_ins;
  logic [31:0] id_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc, id_ready,
    output id_valid, id_ins, id_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc, id_ready,
    input  id_valid, id_ins, id_pc
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch PC owner, credit-limited imem requester and prefetch queue
// feeding IF/ID; redirects flush the queue and drop stale responses.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        discard_q, discard_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  logic [31:0] ins_q [DEPTH];
  logic [31:0] pc_q  [DEPTH];

  logic credit_ok;
  logic grant;
  logic enq;
  logic drop;
  logic deq;
  logic id_valid;

  // Queue entries plus in-flight requests may never exceed DEPTH.
  assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q})
                     < {1'b0, DEPTH_C};

  assign id_valid        = (count_q != '0);
  assign bus.imem_req    = !rst && !bus.redirect && credit_ok;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.id_valid    = id_valid;
  assign bus.id_ins      = ins_q[head_q];
  assign bus.id_pc       = pc_q[head_q];

  // Next-state for PCs, counters and pointers; redirect wins.
  always_comb begin
    grant      = bus.imem_req && bus.imem_gnt;
    drop       = bus.imem_rvalid && (discard_q != '0);
    enq        = bus.imem_rvalid && (discard_q == '0)
                 && !bus.redirect;
    deq        = id_valid && bus.id_ready && !bus.redirect;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    outst_d    = outst_q + cnt_t'(grant)
                 - cnt_t'(bus.imem_rvalid);
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      discard_d  = outst_q - cnt_t'(bus.imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (drop)  discard_d  = discard_q - cnt_t'(1);
      if (enq) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + ptr_t'(1);
      end
      if (deq) head_d = head_q + ptr_t'(1);
      count_d = count_q + cnt_t'(enq) - cnt_t'(deq);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage: instruction and its pc+4 written at the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else if (enq) begin
      ins_q[tail_q] <= bus.imem_rdata;
      pc_q[tail_q]  <= resp_pc_q + 32'd4;
    end
  end

  // A response into a full queue means the memory broke the credit rule.
  assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rvalid && count_q == DEPTH_C));

endmodule
